// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings, shadow-stage records and small helpers for the hazard unit.
package hazard_ctrl_pkg;

  // Forwarding mux select codes
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  // Tuse 3 means the operand is never read
  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef enum logic [1:0] {
    MD_NONE = 2'd0,
    MD_MULT = 2'd1,
    MD_DIV  = 2'd2,
    MD_RSVD = 2'd3
  } md_op_e;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wba;
    logic [1:0] tnew;
  } e_slot_t;

  typedef struct packed {
    logic [4:0] rt;
    logic [4:0] wba;
    logic [1:0] tnew;
  } m_slot_t;

  function automatic logic [1:0] sat_dec2(input logic [1:0] x);
    return (x == 2'd0) ? 2'd0 : x - 2'd1;
  endfunction

  // A producer matches a source only when it really writes a register ($0 excluded)
  function automatic logic hit(input logic [4:0] wba, input logic [4:0] src);
    return (wba != 5'd0) && (wba == src);
  endfunction

  // D-stage select, youngest ready producer wins
  function automatic logic [1:0] fwd_d(input logic [4:0] src, input e_slot_t e,
                                       input m_slot_t m, input logic [4:0] w_wba);
    if (hit(e.wba, src) && e.tnew == 2'd0) return FWD_E;
    if (hit(m.wba, src) && m.tnew == 2'd0) return FWD_M;
    if (hit(w_wba, src))                   return FWD_W;
    return FWD_RF;
  endfunction

  // E-stage select, producers in M or W only
  function automatic logic [1:0] fwd_e(input logic [4:0] src, input m_slot_t m,
                                       input logic [4:0] w_wba);
    if (hit(m.wba, src) && m.tnew == 2'd0) return FWD_M;
    if (hit(w_wba, src))                   return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_ctrl.sv
// Mult/div occupancy counter and the HI/LO stall term for the D instruction.
module md_busy_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] md_op_E,
  input  logic       md_use_D,
  output logic       md_busy,
  output logic       md_stall
);

  logic [CNT_W-1:0] cnt;
  logic             md_start;

  assign md_start = (md_op_E == MD_MULT) || (md_op_E == MD_DIV);
  assign md_busy  = (cnt != '0);
  // The op still sitting in E counts as busy too, so a HI/LO user never slips past it
  assign md_stall = md_use_D && (md_start || md_busy);

  // Reload on every new mult/div (even mid-operation), otherwise count down to zero
  always_ff @(posedge clk) begin
    if (!reset)                    cnt <= '0;
    else if (md_op_E == MD_MULT)   cnt <= CNT_W'(MULT_LAT);
    else if (md_op_E == MD_DIV)    cnt <= CNT_W'(DIV_LAT);
    else if (cnt != '0)            cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage core: shadow pipeline of destinations/Tnew,
// stall generation and forwarding selects for the D, E and M stages.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] tuse_rs_D,
  input  logic [1:0] tuse_rt_D,
  input  logic [4:0] wba_D,
  input  logic [1:0] tnew_D,
  input  logic       md_use_D,
  input  logic [1:0] md_op_E,
  output logic       stall,
  output logic [1:0] fwd_rs_D,
  output logic [1:0] fwd_rt_D,
  output logic [1:0] fwd_rs_E,
  output logic [1:0] fwd_rt_E,
  output logic       fwd_rt_M,
  output logic       md_busy
);

  e_slot_t    e_q;
  m_slot_t    m_q;
  logic [4:0] w_wba;
  logic       md_stall;
  logic       data_stall;

  md_busy_ctrl #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) u_md (
    .clk      (clk),
    .reset    (reset),
    .md_op_E  (md_op_E),
    .md_use_D (md_use_D),
    .md_busy  (md_busy),
    .md_stall (md_stall)
  );

  // Shadow pipeline advances every cycle; a stall pushes a bubble into E
  always_ff @(posedge clk) begin
    if (!reset) begin
      e_q   <= '0;
      m_q   <= '0;
      w_wba <= '0;
    end else begin
      e_q   <= stall ? '0 : '{rs: rs_D, rt: rt_D, wba: wba_D, tnew: tnew_D};
      m_q   <= '{rt: e_q.rt, wba: e_q.wba, tnew: sat_dec2(e_q.tnew)};
      w_wba <= m_q.wba;
    end
  end

  // Stall when an in-flight result will not be ready by the time D needs it
  always_comb begin
    data_stall = 1'b0;
    if (hit(e_q.wba, rs_D) && e_q.tnew > tuse_rs_D) data_stall = 1'b1;
    if (hit(m_q.wba, rs_D) && m_q.tnew > tuse_rs_D) data_stall = 1'b1;
    if (hit(e_q.wba, rt_D) && e_q.tnew > tuse_rt_D) data_stall = 1'b1;
    if (hit(m_q.wba, rt_D) && m_q.tnew > tuse_rt_D) data_stall = 1'b1;
    stall = data_stall | md_stall;
  end

  // Forwarding selects, purely from the shadow state and current D sources
  always_comb begin
    fwd_rs_D = fwd_d(rs_D, e_q, m_q, w_wba);
    fwd_rt_D = fwd_d(rt_D, e_q, m_q, w_wba);
    fwd_rs_E = fwd_e(e_q.rs, m_q, w_wba);
    fwd_rt_E = fwd_e(e_q.rt, m_q, w_wba);
    fwd_rt_M = hit(w_wba, m_q.rt);
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed table of pipeline scenarios followed by random traffic checked
// against an instruction-level reference model.
module tb_hazard_ctrl;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_D, rt_D, wba_D;
  logic [1:0] tuse_rs_D, tuse_rt_D, tnew_D, md_op_E;
  logic       md_use_D;
  logic       stall, fwd_rt_M, md_busy;
  logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .rs_D(rs_D), .rt_D(rt_D),
    .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D), .wba_D(wba_D), .tnew_D(tnew_D),
    .md_use_D(md_use_D), .md_op_E(md_op_E), .stall(stall),
    .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D), .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E),
    .fwd_rt_M(fwd_rt_M), .md_busy(md_busy)
  );

  // {stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M, md_busy}
  function automatic logic [10:0] ex(int st, int rsd, int rtd, int rse, int rte, int rtm, int bz);
    return {st[0], rsd[1:0], rtd[1:0], rse[1:0], rte[1:0], rtm[0], bz[0]};
  endfunction

  task automatic check(input string tag, input logic [10:0] exp);
    logic [10:0] act;
    act = {stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M, md_busy};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got st/rsD/rtD/rsE/rtE/rtM/busy=%b want %b", tag, act, exp);
    end
  endtask

  typedef struct {
    bit          chk;
    bit          rst;
    logic [4:0]  rs, rt;
    logic [1:0]  trs, trt;
    logic [4:0]  wba;
    logic [1:0]  tnew;
    bit          mdu;
    logic [1:0]  op;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit chk, input bit rst, input int rs, input int rt, input int trs,
                     input int trt, input int wba, input int tnew, input bit mdu, input int op,
                     input logic [10:0] exp);
    vec_t v;
    v.chk = chk; v.rst = rst; v.rs = 5'(rs); v.rt = 5'(rt);
    v.trs = 2'(trs); v.trt = 2'(trt); v.wba = 5'(wba); v.tnew = 2'(tnew);
    v.mdu = mdu; v.op = 2'(op); v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic drive(input bit rst, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] trs, input logic [1:0] trt, input logic [4:0] wba,
                       input logic [1:0] tnew, input bit mdu, input logic [1:0] op);
    reset = rst; rs_D = rs; rt_D = rt; tuse_rs_D = trs; tuse_rt_D = trt;
    wba_D = wba; tnew_D = tnew; md_use_D = mdu; md_op_E = op;
  endtask

  // Reference model: instructions in flight, E=0, M=1, W=2, with Tnew as issued
  typedef struct { int rs, rt, wba, tnew; } ins_t;
  ins_t pipe[3];
  int   now, last_t, last_lat;

  function automatic int remain(int k);
    return (pipe[k].tnew - k > 0) ? pipe[k].tnew - k : 0;
  endfunction

  function automatic int ref_fwd(int s, int first);
    if (s == 0) return 0;
    for (int k = first; k < 3; k++)
      if (pipe[k].wba == s && remain(k) == 0) return k + 1;
    return 0;
  endfunction

  function automatic bit src_stalls(int s, int tuse);
    if (s == 0) return 0;
    for (int k = 0; k < 2; k++)
      if (pipe[k].wba == s && remain(k) > tuse) return 1;
    return 0;
  endfunction

  initial begin
    int st, bz, rtm;
    bit valid;
    logic [10:0] e;

    // lw $1 then addu rs=$1: one stall cycle, then E forward from W
    add(0, 0, 0, 0, 3, 3, 0, 0, 0, 0, '0);
    add(1, 1, 5, 0, 1, 3, 1, 2, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
    add(1, 1, 1, 6, 1, 1, 7, 1, 0, 0, ex(1, 0, 0, 0, 0, 0, 0));
    add(1, 1, 1, 6, 1, 1, 7, 1, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
    add(1, 1, 0, 0, 3, 3, 0, 0, 0, 0, ex(0, 0, 0, 3, 0, 0, 0));
    // addu $2 then beq $2 (tuse 0): one stall, then D forward from M
    add(1, 1, 8, 0, 1, 3, 2, 1, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
    add(1, 1, 2, 0, 0, 3, 0, 0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0));
    add(1, 1, 2, 0, 0, 3, 0, 0, 0, 0, ex(0, 2, 0, 0, 0, 0, 0));
    // jal $31 enters D while beq reaches E with $2 in W
    add(1, 1, 0, 0, 3, 3, 31, 0, 0, 0, ex(0, 0, 0, 3, 0, 0, 0));
    // jr $31 behind jal: no stall, forward PC8 from E
    add(1, 1, 31, 0, 0, 3, 0, 0, 0, 0, ex(0, 1, 0, 0, 0, 0, 0));
    // lw $3 in D while jr in E picks $31 from M
    add(1, 1, 0, 0, 1, 3, 3, 2, 0, 0, ex(0, 0, 0, 2, 0, 0, 0));
    // sw rt=$3 (tuse 2) right behind lw: no stall
    add(1, 1, 0, 3, 1, 2, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
    add(1, 1, 0, 0, 3, 3, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
    add(1, 1, 0, 0, 3, 3, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 1, 0));
    add(1, 1, 0, 0, 3, 3, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
    // div in E with mflo in D: stall DIV_LAT+1 cycles
    add(1, 1, 0, 0, 3, 3, 4, 1, 1, 2, ex(1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < DIV_LAT; i++)
      add(1, 1, 0, 0, 3, 3, 4, 1, 1, 0, ex(1, 0, 0, 0, 0, 0, 1));
    add(1, 1, 0, 0, 3, 3, 4, 1, 1, 0, ex(0, 0, 0, 0, 0, 0, 0));
    add(1, 1, 0, 0, 3, 3, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
    // mult in E, then reset abandons it
    add(1, 1, 0, 0, 3, 3, 0, 0, 0, 1, ex(0, 0, 0, 0, 0, 0, 0));
    add(1, 0, 0, 0, 3, 3, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 1));
    add(1, 1, 4, 0, 0, 3, 4, 1, 1, 0, ex(0, 0, 0, 0, 0, 0, 0));
    // data and MD stall together: one stall
    add(1, 1, 4, 0, 0, 3, 0, 0, 1, 1, ex(1, 0, 0, 0, 0, 0, 0));
    add(1, 1, 0, 0, 3, 3, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 1));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].rs, tbl[i].rt, tbl[i].trs, tbl[i].trt,
            tbl[i].wba, tbl[i].tnew, tbl[i].mdu, tbl[i].op);
      #2;
      if (tbl[i].chk) check($sformatf("dir%0d", i), tbl[i].exp);
    end

    // Random traffic against the model; first cycle is a reset
    valid = 0; now = 0; last_t = -1000; last_lat = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      drive((c == 0) ? 1'b0 : ($urandom_range(0, 39) != 0),
            5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 4)), 2'($urandom_range(0, 2)),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 11) == 0) ? 2'd1 :
            ($urandom_range(0, 11) == 0) ? 2'd2 :
            ($urandom_range(0, 15) == 0) ? 2'd3 : 2'd0);
      #2;
      bz  = (now > last_t) && (now - last_t <= last_lat);
      st  = src_stalls(rs_D, tuse_rs_D) || src_stalls(rt_D, tuse_rt_D) ||
            (md_use_D && (md_op_E == 2'd1 || md_op_E == 2'd2 || bz));
      rtm = (pipe[1].rt != 0) && (pipe[2].wba == pipe[1].rt);
      e   = ex(st, ref_fwd(rs_D, 0), ref_fwd(rt_D, 0),
               ref_fwd(pipe[0].rs, 1), ref_fwd(pipe[0].rt, 1), rtm, bz);
      if (valid) check($sformatf("rnd%0d", c), e);
      @(posedge clk);
      if (!reset) begin
        foreach (pipe[k]) pipe[k] = '{0, 0, 0, 0};
        last_t = -1000;
        valid = 1;
      end else begin
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = st ? '{0, 0, 0, 0} : '{int'(rs_D), int'(rt_D), int'(wba_D), int'(tnew_D)};
        if (md_op_E == 2'd1) begin last_t = now; last_lat = MULT_LAT; end
        if (md_op_E == 2'd2) begin last_t = now; last_lat = DIV_LAT;  end
      end
      now++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
